// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsa_state_t;

    // Digit counter width; never zero, even when one digit covers the whole word.
    function automatic int unsigned dsa_cnt_w(input int unsigned ndig);
        return (ndig > 1) ? int'($clog2(ndig)) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational ripple-carry slice handling one DIGIT-bit digit.
// With DIGIT_SERIAL_ADDER_OVF_EN the carry into the top bit is exported
// so the parent can derive signed overflow.
module digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             c_msb
`endif
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[DIGIT];

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    assign c_msb = carry[DIGIT-1];
`endif

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// cycle, LSB first, behind valid/ready handshakes on both sides.
// Optional signed-overflow output enabled by DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NDIG  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CNT_W = dsa_cnt_w(NDIG);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("digit_serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    dsa_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             last_dig;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
    logic             dig_cmsb;
`endif

    // Operands shift right each RUN cycle, so the current digit is always at the bottom.
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .sum   (dig_sum),
        .cout  (dig_cout)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ,
        .c_msb (dig_cmsb)
`endif
    );

    assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_dig)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs, decoded from registered state only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state: operand capture on accept, one digit per RUN cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction as a + ~b + ~cin.
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d = a_q >> DIGIT;
                b_d = b_q >> DIGIT;
                s_d[32'(cnt_q) * DIGIT +: DIGIT] = dig_sum;
                carry_d = dig_cout;
                if (last_dig) begin
                    cout_d = dig_cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                    ovf_d  = dig_cmsb ^ dig_cout;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: one instance with DIGIT=2 and one
// with DIGIT=WIDTH=8 share inputs; sel8 routes in_valid and selects outputs.
module tb_digit_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, in_valid, sel8, cin, sub, out_ready;
    logic [7:0] a, b;

    logic       iv2, iv8;
    logic       in_ready2, out_valid2, cout2;
    logic       in_ready8, out_valid8, cout8;
    logic [7:0] s2, s8;
    logic       in_ready_m, out_valid_m, cout_m;
    logic [7:0] s_m;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic       ovf2, ovf8, ovf_m;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign iv2         = in_valid & ~sel8;
    assign iv8         = in_valid & sel8;
    assign in_ready_m  = sel8 ? in_ready8  : in_ready2;
    assign out_valid_m = sel8 ? out_valid8 : out_valid2;
    assign s_m         = sel8 ? s8         : s2;
    assign cout_m      = sel8 ? cout8      : cout2;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    assign ovf_m       = sel8 ? ovf8       : ovf2;
`endif

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .s         (s2),
        .cout      (cout2)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf2)
`endif
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (in_ready8),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .s         (s8),
        .cout      (cout8)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one op (called #1 after an edge with the selected DUT idle) and
    // count cycles from the accept edge until out_valid, bounded by max_cyc.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                          input logic tsub, input int max_cyc, output int lat);
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_m && lat < max_cyc) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handoff(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_in_ready_after"}, 32'(in_ready_m), 32'd1);
        check({name, "_out_valid_after"}, 32'(out_valid_m), 32'd0);
    endtask

    task automatic apply_vec(input string name, input vec_t v, input int exp_lat);
        int lat;
        run_op(v.a, v.b, v.cin, v.sub, 20, lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_s"}, 32'(s_m), 32'(v.s));
        check({name, "_cout"}, 32'(cout_m), 32'(v.cout));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        check({name, "_ovf"}, 32'(ovf_m), 32'(v.ovf));
`endif
        handoff(name);
    endtask

    initial begin
        vec_t vecs2[8];
        vec_t vecs8[3];
        int   lat;

        //         a      b      cin   sub   s      cout  ovf
        vecs2[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs2[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs2[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs2[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs2[4] = '{8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs2[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs2[6] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs2[7] = '{8'h0F, 8'h0F, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        vecs8[0] = '{8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0};
        vecs8[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs8[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        sel8      = 1'b0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state, observed in the first cycle after the reset edge.
        @(posedge clk); #1;
        check("rst_in_ready2", 32'(in_ready2), 32'd1);
        check("rst_out_valid2", 32'(out_valid2), 32'd0);
        check("rst_s2", 32'(s2), 32'd0);
        check("rst_cout2", 32'(cout2), 32'd0);
        check("rst_in_ready8", 32'(in_ready8), 32'd1);
        check("rst_out_valid8", 32'(out_valid8), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // DIGIT=2: latency of 4 cycles.
        for (int i = 0; i < 8; i++) begin
            apply_vec($sformatf("d2_vec%0d", i), vecs2[i], 4);
        end

        // Backpressure: result held while out_ready is low; in_valid ignored.
        run_op(8'h33, 8'h44, 1'b0, 1'b0, 20, lat);
        check("bp_latency", 32'(lat), 32'd4);
        a        = 8'hFF;
        b        = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_out_valid%0d", i), 32'(out_valid_m), 32'd1);
            check($sformatf("bp_s%0d", i), 32'(s_m), 32'h77);
            check($sformatf("bp_cout%0d", i), 32'(cout_m), 32'd0);
            check($sformatf("bp_in_ready%0d", i), 32'(in_ready_m), 32'd0);
        end
        in_valid = 1'b0;
        handoff("bp");
        @(posedge clk); #1;
        check("bp_idle_out_valid", 32'(out_valid_m), 32'd0);
        check("bp_idle_in_ready", 32'(in_ready_m), 32'd1);

        // Reset during the second RUN cycle aborts silently.
        a        = 8'h55;
        b        = 8'h22;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rr_out_valid", 32'(out_valid_m), 32'd0);
        check("rr_s", 32'(s_m), 32'd0);
        check("rr_in_ready", 32'(in_ready_m), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("rr_no_late_valid", 32'(out_valid_m), 32'd0);
        apply_vec("rr_next", '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0}, 4);

        // DIGIT=WIDTH: single-cycle latency.
        sel8 = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            apply_vec($sformatf("d8_vec%0d", i), vecs8[i], 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit in case a wait never resolves.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
